vec_sequencer: RTL and testbench

// Stimulus stage that sits directly upstream of circuit3. Holds a small

---
 rtl/vec_sequencer.sv | 130 +++++++++++++
 tb/tb_vec_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_sequencer.sv
// rtl/vec_sequencer.sv - steps a programmable table of {i1,i2} vectors into circuit3 and captures {cout,sum}
module vec_sequencer #(
  parameter int NVEC = 6,
  parameter int HOLD = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       load_en,
  input  logic [2:0] load_addr,
  input  logic [3:0] load_data,
  input  logic       sum_in,
  input  logic       cout_in,
  output logic [2:0] i1,
  output logic       i2,
  output logic       busy,
  output logic [2:0] vec_idx,
  output logic       result_valid,
  output logic [1:0] result,
  output logic [2:0] result_idx,
  output logic       done
);

  localparam int            HW       = (HOLD > 1) ? $clog2(HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LD  = HW'(HOLD - 1);
  localparam logic [2:0]    LAST_IDX = 3'(NVEC - 1);
  localparam logic [3:0]    NVEC_W   = 4'(NVEC);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOLD    = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [HW-1:0] hold_cnt;
  logic [3:0]    tbl [8];
  logic          last_vec;
  logic          wr_ok;
  logic [2:0]    vec_nx;

  assign last_vec = (vec_idx == LAST_IDX);
  assign vec_nx   = vec_idx + 3'd1;
  assign wr_ok    = load_en && !busy && ({1'b0, load_addr} < NVEC_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start) state_nx = S_HOLD;
      S_HOLD:    if (hold_cnt == '0) state_nx = S_CAPTURE;
      S_CAPTURE: state_nx = last_vec ? S_DONE : S_HOLD;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_HOLD, S_CAPTURE: busy = 1'b1;
      S_DONE:            done = 1'b1;
      default: ;
    endcase
  end

  // Reset restores the default pattern table[k] = {k, k[0]}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        tbl[k] <= {3'(k), k[0]};
      end
    end else if (wr_ok) begin
      tbl[load_addr] <= load_data;
    end
  end

  // Table reads here see the pre-write value, so a start edge that also
  // writes entry 0 still launches the old entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1           <= '0;
      i2           <= 1'b0;
      vec_idx      <= '0;
      hold_cnt     <= '0;
      result       <= '0;
      result_idx   <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            {i1, i2} <= tbl[0];
            vec_idx  <= '0;
            hold_cnt <= HOLD_LD;
          end
        end
        S_HOLD: begin
          if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
        end
        S_CAPTURE: begin
          result       <= {cout_in, sum_in};
          result_idx   <= vec_idx;
          result_valid <= 1'b1;
          if (!last_vec) begin
            vec_idx  <= vec_nx;
            {i1, i2} <= tbl[vec_nx];
            hold_cnt <= HOLD_LD;
          end
        end
        S_DONE: begin
          {i1, i2} <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_sequencer.sv
// tb/tb_vec_sequencer.sv - self-checking bench for vec_sequencer with circuit3 loopback stub
module tb_vec_sequencer;

  localparam int NVEC   = 6;
  localparam int HOLD   = 2;
  localparam int PER    = HOLD + 1;
  localparam int RUNLEN = NVEC * PER;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       load_en;
  logic [2:0] load_addr;
  logic [3:0] load_data;
  logic       sum_in;
  logic       cout_in;
  logic [2:0] i1;
  logic       i2;
  logic       busy;
  logic [2:0] vec_idx;
  logic       result_valid;
  logic [1:0] result;
  logic [2:0] result_idx;
  logic       done;

  assign sum_in  = i2;
  assign cout_in = i1[0];

  vec_sequencer #(.NVEC(NVEC), .HOLD(HOLD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .sum_in       (sum_in),
    .cout_in      (cout_in),
    .i1           (i1),
    .i2           (i2),
    .busy         (busy),
    .vec_idx      (vec_idx),
    .result_valid (result_valid),
    .result       (result),
    .result_idx   (result_idx),
    .done         (done)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] mdl [8];
  logic [1:0] held_res;
  logic [2:0] held_idx;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mdl_defaults();
    for (int k = 0; k < 8; k++) mdl[k] = {3'(k), k[0]};
    held_res = '0;
    held_idx = '0;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({i1, i2, busy, vec_idx, result_valid, result, result_idx, done} !== 14'd0) begin
      failures++;
      $display("FAIL %s zero_outputs got=%b required=0", name,
               {i1, i2, busy, vec_idx, result_valid, result, result_idx, done});
    end
  endtask

  task automatic write_entry(input logic [2:0] addr, input logic [3:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    step();
    load_en = 1'b0;
    if (int'(addr) < NVEC) mdl[addr] = data;
  endtask

  // Expected behaviour is derived from cycle position c after the start edge:
  // vector k = c/PER is driven for PER cycles, strobes land on multiples of PER.
  task automatic run_check(input string name, input bit co_load, input logic [2:0] co_addr,
                           input logic [3:0] co_data, input int mid_start, input int mid_load,
                           input int abort_at);
    logic [3:0] snap [8];
    logic [3:0] exp_vec;
    logic       exp_rv;
    logic       exp_busy;
    logic       exp_done;
    int         n_rv;
    int         n_done;
    int         k;
    snap   = mdl;
    n_rv   = 0;
    n_done = 0;
    start     = 1'b1;
    load_en   = co_load;
    load_addr = co_addr;
    load_data = co_data;
    step();
    start   = 1'b0;
    load_en = 1'b0;
    if (co_load && int'(co_addr) < NVEC) mdl[co_addr] = co_data;
    for (int c = 0; c < RUNLEN + 3; c++) begin
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_zero({name, "_async_reset"});
        rst_n = 1'b1;
        mdl_defaults();
        return;
      end
      k        = c / PER;
      exp_busy = (c < RUNLEN);
      exp_done = (c == RUNLEN);
      exp_vec  = exp_busy ? snap[k] : (exp_done ? snap[NVEC-1] : 4'd0);
      exp_rv   = (c > 0) && (c % PER == 0) && (c <= RUNLEN);
      if (exp_rv) begin
        held_res = snap[k-1][1:0];
        held_idx = 3'(k - 1);
      end
      checks++;
      if ({i1, i2} !== exp_vec) begin
        failures++;
        $display("FAIL %s vector c=%0d got=%b required=%b", name, c, {i1, i2}, exp_vec);
      end
      checks++;
      if (busy !== exp_busy) begin
        failures++;
        $display("FAIL %s busy c=%0d got=%b required=%b", name, c, busy, exp_busy);
      end
      checks++;
      if (done !== exp_done) begin
        failures++;
        $display("FAIL %s done c=%0d got=%b required=%b", name, c, done, exp_done);
      end
      checks++;
      if (result_valid !== exp_rv) begin
        failures++;
        $display("FAIL %s result_valid c=%0d got=%b required=%b", name, c, result_valid, exp_rv);
      end
      checks++;
      if ({result, result_idx} !== {held_res, held_idx}) begin
        failures++;
        $display("FAIL %s result c=%0d got=%b/%0d required=%b/%0d", name, c,
                 result, result_idx, held_res, held_idx);
      end
      if (exp_busy) begin
        checks++;
        if (vec_idx !== 3'(k)) begin
          failures++;
          $display("FAIL %s vec_idx c=%0d got=%0d required=%0d", name, c, vec_idx, k);
        end
      end
      n_rv   += int'(result_valid);
      n_done += int'(done);
      if (c == mid_start) start = 1'b1;
      if (c == mid_load) begin
        load_en   = 1'b1;
        load_addr = 3'd1;
        load_data = 4'b0000;
      end
      step();
      start   = 1'b0;
      load_en = 1'b0;
    end
    checks++;
    if (n_rv !== NVEC || n_done !== 1) begin
      failures++;
      $display("FAIL %s strobe_count got=%0d/%0d required=%0d/1", name, n_rv, n_done, NVEC);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    check_zero("reset");
    rst_n = 1'b1;
    step();
    check_zero("post_reset_idle");
  endtask

  task automatic test_default_run();
    run_check("default_run", 1'b0, 3'd0, 4'd0, -1, -1, -1);
  endtask

  task automatic test_table_write();
    write_entry(3'd2, 4'b1101);
    run_check("table_write", 1'b0, 3'd0, 4'd0, -1, -1, -1);
  endtask

  task automatic test_load_while_busy();
    run_check("load_busy_run", 1'b0, 3'd0, 4'd0, -1, 4, -1);
    run_check("load_busy_after", 1'b0, 3'd0, 4'd0, -1, -1, -1);
  endtask

  task automatic test_start_while_busy();
    run_check("start_busy", 1'b0, 3'd0, 4'd0, 7, -1, -1);
    run_check("start_in_done", 1'b0, 3'd0, 4'd0, RUNLEN, -1, -1);
  endtask

  task automatic test_reset_mid_run();
    run_check("reset_mid_run", 1'b0, 3'd0, 4'd0, -1, -1, 3 * PER + 1);
    step();
    run_check("after_reset_run", 1'b0, 3'd0, 4'd0, -1, -1, -1);
  endtask

  task automatic test_addr_bounds_and_start_load();
    write_entry(3'd6, 4'b1111);
    write_entry(3'd7, 4'b1010);
    run_check("addr_bounds", 1'b0, 3'd0, 4'd0, -1, -1, -1);
    run_check("start_with_load0", 1'b1, 3'd0, 4'b1111, -1, -1, -1);
    run_check("load0_next_run", 1'b0, 3'd0, 4'd0, -1, -1, -1);
  endtask

  task automatic test_random_tables();
    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < 5; w++) begin
        write_entry(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      end
      run_check("random_table", 1'b0, 3'd0, 4'd0,
                $urandom_range(0, RUNLEN), $urandom_range(0, RUNLEN - 1), -1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    mdl_defaults();
    test_reset();
    test_default_run();
    test_table_write();
    test_load_while_busy();
    test_start_while_busy();
    test_reset_mid_run();
    test_addr_bounds_and_start_load();
    test_random_tables();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
